// File: rtl/traffic_master.sv
// traffic_master: self-contained pseudo-random bus master for crossbar stress.
//
// Issues reads and writes drawn from a free-running 32-bit Galois LFSR toward one crossbar
// master port, walking slaves sequentially (MODE 0) or picking them at random (MODE 1).
// Tracks completions, enforces a response timeout and keeps statistics.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   enable              start/continue issuing (never aborts an in-flight transaction)
//   master_slave_*      req/addr/cmd/wdata toward the slave (all zero outside REQ)
//   slave_master_*      ack (request accepted), resp + rdata (read response)
//   done                sticky, NUM_TXN completions reached
//   err_timeout         sticky, at least one transaction timed out
//   wr_cnt, rd_cnt      completed writes/reads (wrapping)
//   err_cnt             timeouts (saturating)
//   rd_xor              XOR of all received read data
module traffic_master #(
    parameter logic [31:0] SEED          = 32'h1,
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned SLAVE_BITS    = 2,
    parameter int unsigned OFFSET_W      = 8,
    parameter int unsigned TXN_PER_SLAVE = 16,
    parameter int unsigned MODE          = 0,
    parameter int unsigned GAP_W         = 2,
    parameter int unsigned TIMEOUT       = 255,
    parameter int unsigned NUM_TXN       = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic              master_slave_req,
    output logic [ADDR_W-1:0] master_slave_addr,
    output logic              master_slave_cmd,
    output logic [DATA_W-1:0] master_slave_wdata,
    input  logic              slave_master_ack,
    input  logic [DATA_W-1:0] slave_master_rdata,
    input  logic              slave_master_resp,
    output logic              done,
    output logic              err_timeout,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       err_cnt,
    output logic [DATA_W-1:0] rd_xor
);

    localparam logic [31:0] LfsrPoly = 32'h8020_0003;
    localparam logic [31:0] SeedNz   = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam int unsigned GapW     = (GAP_W > 0) ? GAP_W : 1;
    localparam int unsigned Rep      = (DATA_W + 31) / 32;

    typedef enum logic [1:0] {StIdle, StReq, StWaitResp, StGap} state_e;

    state_e                state_q, state_d;
    logic [31:0]           lfsr_q, lfsr_d;
    logic                  cmd_q, cmd_d;
    logic [OFFSET_W-1:0]   offset_q, offset_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [SLAVE_BITS-1:0] rslave_q, rslave_d;
    logic [SLAVE_BITS-1:0] walk_q, walk_d;
    logic [31:0]           per_slave_q, per_slave_d;
    logic [GapW-1:0]       gap_q, gap_d;
    logic [GapW-1:0]       gap_cnt_q, gap_cnt_d;
    logic [31:0]           tmo_q, tmo_d;
    logic [31:0]           cmpl_q, cmpl_d;
    logic                  done_q, done_d;
    logic                  err_to_q, err_to_d;
    logic [15:0]           wr_q, wr_d;
    logic [15:0]           rd_q, rd_d;
    logic [15:0]           err_q, err_d;
    logic [DATA_W-1:0]     xor_q, xor_d;

    logic                  draw, complete, fold, timeout, tmo_hit;
    logic [Rep*32-1:0]     lfsr_rep;

    assign lfsr_rep = {Rep{lfsr_q}};
    assign tmo_hit  = (tmo_q == 32'(TIMEOUT - 1));

    always_comb begin
        lfsr_d      = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrPoly : 32'd0);
        state_d     = state_q;
        cmd_d       = cmd_q;
        offset_d    = offset_q;
        wdata_d     = wdata_q;
        rslave_d    = rslave_q;
        walk_d      = walk_q;
        per_slave_d = per_slave_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        tmo_d       = tmo_q;
        cmpl_d      = cmpl_q;
        done_d      = done_q;
        err_to_d    = err_to_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        err_d       = err_q;
        xor_d       = xor_q;
        draw        = 1'b0;
        complete    = 1'b0;
        fold        = 1'b0;
        timeout     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable && !done_q) begin
                    state_d = StReq;
                    draw    = 1'b1;
                end
            end
            StReq: begin
                // A response without ack is ignored here.
                if (slave_master_ack) begin
                    if (cmd_q) begin
                        complete = 1'b1;
                    end else if (slave_master_resp) begin
                        complete = 1'b1;
                        fold     = 1'b1;
                    end else begin
                        state_d = StWaitResp;
                    end
                end else if (tmo_hit) begin
                    timeout = 1'b1;
                end
            end
            StWaitResp: begin
                if (slave_master_resp) begin
                    complete = 1'b1;
                    fold     = 1'b1;
                end else if (tmo_hit) begin
                    timeout = 1'b1;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapW'(1)) begin
                    if (enable) begin
                        state_d = StReq;
                        draw    = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (complete) begin
            cmpl_d = cmpl_q + 32'd1;
            if (cmd_q) begin
                wr_d = wr_q + 16'd1;
            end else begin
                rd_d = rd_q + 16'd1;
            end
            if (fold) begin
                xor_d = xor_q ^ slave_master_rdata;
            end
            if (per_slave_q + 32'd1 == 32'(TXN_PER_SLAVE)) begin
                per_slave_d = 32'd0;
                walk_d      = walk_q + SLAVE_BITS'(1);
            end else begin
                per_slave_d = per_slave_q + 32'd1;
            end
            if ((NUM_TXN != 0) && (cmpl_d == 32'(NUM_TXN))) begin
                done_d  = 1'b1;
                state_d = StIdle;
            end else if (!enable) begin
                state_d = StIdle;
            end else if (gap_q == '0) begin
                state_d = StReq;
                draw    = 1'b1;
            end else begin
                state_d   = StGap;
                gap_cnt_d = gap_q;
            end
        end

        // A timed-out transaction always releases req for at least one cycle.
        if (timeout) begin
            err_to_d = 1'b1;
            if (err_q != 16'hFFFF) begin
                err_d = err_q + 16'd1;
            end
            if (!enable) begin
                state_d = StIdle;
            end else begin
                state_d   = StGap;
                gap_cnt_d = (gap_q == '0) ? GapW'(1) : gap_q;
            end
        end

        if (draw) begin
            cmd_d    = lfsr_q[0];
            offset_d = lfsr_q[OFFSET_W:1];
            wdata_d  = lfsr_q[0] ? lfsr_rep[DATA_W-1:0] : '0;
            rslave_d = lfsr_q[31 -: SLAVE_BITS];
            gap_d    = (GAP_W > 0) ? lfsr_q[16 +: GapW] : '0;
        end

        // Timeout counter restarts on every state entry, including back-to-back REQ.
        if ((state_d != state_q) || draw) begin
            tmo_d = 32'd0;
        end else if ((state_q == StReq) || (state_q == StWaitResp)) begin
            tmo_d = tmo_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            lfsr_q      <= SeedNz;
            cmd_q       <= 1'b0;
            offset_q    <= '0;
            wdata_q     <= '0;
            rslave_q    <= '0;
            walk_q      <= '0;
            per_slave_q <= 32'd0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            tmo_q       <= 32'd0;
            cmpl_q      <= 32'd0;
            done_q      <= 1'b0;
            err_to_q    <= 1'b0;
            wr_q        <= 16'd0;
            rd_q        <= 16'd0;
            err_q       <= 16'd0;
            xor_q       <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            cmd_q       <= cmd_d;
            offset_q    <= offset_d;
            wdata_q     <= wdata_d;
            rslave_q    <= rslave_d;
            walk_q      <= walk_d;
            per_slave_q <= per_slave_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            tmo_q       <= tmo_d;
            cmpl_q      <= cmpl_d;
            done_q      <= done_d;
            err_to_q    <= err_to_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            err_q       <= err_d;
            xor_q       <= xor_d;
        end
    end

    always_comb begin
        master_slave_req   = (state_q == StReq);
        master_slave_addr  = '0;
        master_slave_cmd   = 1'b0;
        master_slave_wdata = '0;
        if (master_slave_req) begin
            master_slave_addr[OFFSET_W-1:0]          = offset_q;
            master_slave_addr[ADDR_W-1 -: SLAVE_BITS] = (MODE == 1) ? rslave_q : walk_q;
            master_slave_cmd                          = cmd_q;
            master_slave_wdata                        = wdata_q;
        end
    end

    assign done        = done_q;
    assign err_timeout = err_to_q;
    assign wr_cnt      = wr_q;
    assign rd_cnt      = rd_q;
    assign err_cnt     = err_q;
    assign rd_xor      = xor_q;

endmodule
